// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store split unit: access-size encodings,
// FSM states and the size-to-byte-count decode.
package lsu_pkg;

    localparam logic [3:0] SIZE_B = 4'b0001;
    localparam logic [3:0] SIZE_H = 4'b0010;
    localparam logic [3:0] SIZE_W = 4'b0100;
    localparam logic [3:0] SIZE_D = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Byte count of a one-hot size; any other encoding decodes to 0 so the
    // top can reject it as an error rather than issue an empty beat.
    function automatic logic [3:0] size_bytes(input logic [3:0] size);
        logic [3:0] n;
        case (size)
            SIZE_B:  n = 4'd1;
            SIZE_H:  n = 4'd2;
            SIZE_W:  n = 4'd4;
            SIZE_D:  n = 4'd8;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_shift_ext.sv
// Combinational datapath of the LSU: store-data/byte-mask alignment over a
// two-word window, and load extraction with sign/zero extension.
module lsu_shift_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int BYTES = XLEN / 8,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic [OFF_W-1:0]   off_i,
    input  logic [3:0]         size_i,
    input  logic               unsign_i,
    input  logic [XLEN-1:0]    wdata_i,
    input  logic [2*XLEN-1:0]  rbuf_i,
    output logic [2*XLEN-1:0]  wvec_o,
    output logic [2*BYTES-1:0] mvec_o,
    output logic [XLEN-1:0]    rdata_o
);

    logic [3:0]         n;
    logic [2*BYTES-1:0] base_mask;
    logic [XLEN-1:0]    shifted;
    logic               sign;

    assign n = size_bytes(size_i);

    // Store data moved up by the byte offset; the upper word feeds the second beat.
    always_comb begin
        wvec_o = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};
    end

    // n low bits set, then moved to the byte offset.
    always_comb begin
        base_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(n)) base_mask[i] = 1'b1;
        end
        mvec_o = base_mask << off_i;
    end

    // Pull the addressed bytes down to bit 0, keep n bytes, fill the rest.
    always_comb begin
        rdata_o = '0;
        shifted = XLEN'(rbuf_i >> {off_i, 3'b000});
        sign    = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            if (i + 1 == int'(n)) sign = shifted[8*i+7];
        end
        for (int i = 0; i < BYTES; i++) begin
            rdata_o[8*i +: 8] = (i < int'(n)) ? shifted[8*i +: 8] : {8{sign & ~unsign_i}};
        end
    end

endmodule

// File: rtl/lsu_split_unit.sv
// Sequential load/store unit between EX and the BIU. Accesses that cross a
// bus word become two beats; load beats are merged in a two-word buffer.
module lsu_split_unit
    import lsu_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ADDR_W      = 64,
    parameter int MISALIGN_EN = 1,
    localparam int BYTES = XLEN / 8,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_unsign,
    input  logic [3:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [BYTES-1:0]  bus_bmask,
    input  logic [XLEN-1:0]   bus_rdata
);

    lsu_state_e          state_q, state_d;
    logic                write_q, write_d;
    logic                unsign_q, unsign_d;
    logic [3:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic                split_q, split_d;
    logic                err_q, err_d;
    logic [2*XLEN-1:0]   rbuf_q, rbuf_d;

    logic [3:0]          req_n;
    logic [OFF_W-1:0]    req_off;
    logic                req_split;
    logic                req_err;

    logic [2*XLEN-1:0]   wvec;
    logic [2*BYTES-1:0]  mvec;
    logic [XLEN-1:0]     ext_rdata;
    logic [ADDR_W-1:0]   base;
    logic                beat_act;
    logic                beat_hi;

    // Classify the incoming request so IDLE can go straight to RESP on error.
    always_comb begin
        req_n     = size_bytes(req_size);
        req_off   = req_addr[OFF_W-1:0];
        req_split = (int'(req_off) + int'(req_n)) > BYTES;
        req_err   = (req_n == 4'd0) || (int'(req_n) > BYTES) ||
                    (req_split && (MISALIGN_EN == 0));
    end

    // Next state, request capture and load-buffer fill.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        unsign_d = unsign_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        split_d  = split_q;
        err_d    = err_q;
        rbuf_d   = rbuf_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    unsign_d = req_unsign;
                    size_d   = req_size;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    split_d  = req_split;
                    err_d    = req_err;
                    state_d  = req_err ? ST_RESP : ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (bus_ready) begin
                    if (!write_q) rbuf_d[XLEN-1:0] = bus_rdata;
                    state_d = split_q ? ST_BEAT1 : ST_RESP;
                end
            end
            ST_BEAT1: begin
                if (bus_ready) begin
                    if (!write_q) rbuf_d[2*XLEN-1:XLEN] = bus_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and capture registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            unsign_q <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            split_q  <= 1'b0;
            err_q    <= 1'b0;
            rbuf_q   <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            unsign_q <= unsign_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            split_q  <= split_d;
            err_q    <= err_d;
            rbuf_q   <= rbuf_d;
        end
    end

    lsu_shift_ext #(
        .XLEN(XLEN)
    ) u_shift_ext (
        .off_i    (addr_q[OFF_W-1:0]),
        .size_i   (size_q),
        .unsign_i (unsign_q),
        .wdata_i  (wdata_q),
        .rbuf_i   (rbuf_q),
        .wvec_o   (wvec),
        .mvec_o   (mvec),
        .rdata_o  (ext_rdata)
    );

    // Bus and response outputs; all driven only from registered state so they
    // stay stable while a beat waits for bus_ready.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        beat_act  = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
        beat_hi   = (state_q == ST_BEAT1);
        base      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        bus_valid = beat_act;
        bus_write = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_bmask = '0;
        if (beat_act) begin
            bus_write = write_q;
            // Second beat may wrap past the top of the address space.
            bus_addr  = beat_hi ? base + ADDR_W'(BYTES) : base;
            bus_bmask = beat_hi ? mvec[2*BYTES-1:BYTES] : mvec[BYTES-1:0];
            if (write_q) bus_wdata = beat_hi ? wvec[2*XLEN-1:XLEN] : wvec[XLEN-1:0];
        end
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = rsp_valid & err_q;
        rsp_rdata = (rsp_valid && !err_q && !write_q) ? ext_rdata : '0;
    end

endmodule
